// File: rtl/fifo_rtl_1.sv
// Synchronous FIFO, DEPTH x WIDTH, registered dout valid one clock after an accepted read.
// No stall output: writes when full (without a read) and reads when empty are silently dropped.
module fifo_rtl_1 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wt_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             rd_acc;
  logic             wr_acc;

  // A read frees a slot on the same edge, so a full FIFO can still take a write.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wt_en && (!full || rd_acc);

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rtl_1.sv
// Directed bench for fifo_rtl_1 with hand-computed expected data and flags.
module tb_fifo_rtl_1;

  logic       clk;
  logic       rst;
  logic       wt_en;
  logic       rd_en;
  logic [7:0] din;
  logic [7:0] dout;
  logic       full;
  logic       empty;

  int tests = 0;
  int fails = 0;

  fifo_rtl_1 #(.WIDTH(8), .DEPTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .wt_en (wt_en),
    .rd_en (rd_en),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, need finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wt_en = 1'b1;
    rd_en = 1'b0;
    din   = d;
    tick();
    wt_en = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    wt_en = 1'b0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check(tag, dout, exp);
  endtask

  initial begin
    rst = 1'b0; wt_en = 1'b0; rd_en = 1'b0; din = 8'h00;

    // Asynchronous reset, observed before the first clock edge at t=5.
    #2 rst = 1'b1;
    #1;
    check("rst_dout", dout, 8'h00);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Write 0x01..0x04, then read them back.
    for (int i = 1; i <= 4; i++) push(8'(i));
    check("wr4_empty", empty, 1'b0);
    for (int i = 1; i <= 4; i++) pop_check("rd_order", 8'(i));
    check("rd4_empty", empty, 1'b1);

    // Underflow: reads while empty leave dout and flags alone.
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("under_dout", dout, 8'h04);
      check("under_empty", empty, 1'b1);
    end
    rd_en = 1'b0;

    // Overflow: 10 writes into 8 slots, last two dropped.
    for (int i = 0; i < 10; i++) begin
      push(8'h10 + 8'(i));
      check("ovf_full", full, (i >= 7) ? 1'b1 : 1'b0);
    end
    pop_check("ovf_rd", 8'h10);
    check("ovf_full_drop", full, 1'b0);
    for (int i = 1; i < 8; i++) pop_check("ovf_rd", 8'h10 + 8'(i));
    check("ovf_empty", empty, 1'b1);

    // Simultaneous access with 3 words stored.
    for (int i = 0; i < 3; i++) push(8'hA0 + 8'(i));
    wt_en = 1'b1; rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = 8'hA3 + 8'(i);
      tick();
      check("sim_dout", dout, 8'hA0 + 8'(i));
      check("sim_flags", {full, empty}, 2'b00);
    end
    wt_en = 1'b0; rd_en = 1'b0;
    // Stored now: A5 A6 A7; fill to full with B0..B4.
    for (int i = 0; i < 5; i++) push(8'hB0 + 8'(i));
    check("fill_full", full, 1'b1);
    wt_en = 1'b1; rd_en = 1'b1; din = 8'hC0;
    tick();
    wt_en = 1'b0; rd_en = 1'b0;
    check("simfull_dout", dout, 8'hA5);
    check("simfull_full", full, 1'b1);
    pop_check("drain", 8'hA6);
    pop_check("drain", 8'hA7);
    for (int i = 0; i < 5; i++) pop_check("drain", 8'hB0 + 8'(i));
    pop_check("drain", 8'hC0);
    check("drain_empty", empty, 1'b1);

    // Simultaneous while empty: write only, no bypass to dout.
    wt_en = 1'b1; rd_en = 1'b1; din = 8'h55;
    tick();
    wt_en = 1'b0; rd_en = 1'b0;
    check("simempty_dout", dout, 8'hC0);
    check("simempty_empty", empty, 1'b0);
    pop_check("simempty_rd", 8'h55);
    check("simempty_after", empty, 1'b1);

    // Mid-operation reset with 5 words stored.
    for (int i = 0; i < 5; i++) push(8'hD0 + 8'(i));
    wt_en = 1'b1; rd_en = 1'b1; din = 8'hE0;
    #3 rst = 1'b1;
    #1;
    check("mrst_empty", empty, 1'b1);
    check("mrst_full", full, 1'b0);
    check("mrst_dout", dout, 8'h00);
    tick();
    check("mrst_hold", {dout, full, empty}, {8'h00, 1'b0, 1'b1});
    wt_en = 1'b0; rd_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("mrst_rel_empty", empty, 1'b1);
    push(8'hF0);
    pop_check("mrst_first", 8'hF0);
    check("mrst_end_empty", empty, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
